// File: rtl/intr_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package intr_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_e;

  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  localparam logic [2:0] ADDR_MSTATUS = 3'd0;
  localparam logic [2:0] ADDR_MIE     = 3'd1;
  localparam logic [2:0] ADDR_MTVEC   = 3'd2;
  localparam logic [2:0] ADDR_MEPC    = 3'd3;
  localparam logic [2:0] ADDR_MCAUSE  = 3'd4;
  localparam logic [2:0] ADDR_MIP     = 3'd5;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MT       = 7;
  localparam int IRQ_ME       = 11;

  // Direct mode jumps to the base; vectored mode (mtvec[1:0]==1) offsets by 4*code.
  function automatic logic [DATA_W-1:0] calc_vec(input logic [DATA_W-1:0] mtvec,
                                                 input logic [3:0]        code);
    logic [DATA_W-1:0] base;
    base = {mtvec[DATA_W-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01) calc_vec = base + {{(DATA_W-6){1'b0}}, code, 2'b00};
    else                     calc_vec = base;
  endfunction

endpackage

// File: rtl/intr_prio.sv
// Fixed-priority encoder over enabled pending interrupts; external beats timer.
module intr_prio
  import intr_pkg::*;
(
  input  logic [1:0] pend_i,   // {MEI, MTI}, already masked by mie
  output logic       any_o,
  output logic [3:0] code_o
);

  always_comb begin
    any_o  = |pend_i;
    code_o = 4'd0;
    if (pend_i[1])      code_o = CODE_MEI;
    else if (pend_i[0]) code_o = CODE_MTI;
  end

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: pends timer/external IRQs, raises a trap
// request to the core and owns mstatus/mie/mip/mtvec/mepc/mcause.
//
// state   | meaning
// IDLE    | watching for an eligible interrupt on a valid instruction
// REQ     | trap_req_o held high until the pipeline acknowledges
// HANDLER | handler running; interrupts only pend until mret
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tmr_irq_i,
  input  logic            ext_irq_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            instr_vld_i,
  output logic            trap_req_o,
  input  logic            trap_ack_i,
  output logic [XLEN-1:0] trap_vec_o,
  input  logic            mret_i,
  output logic [XLEN-1:0] epc_o,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [XLEN-1:0] cfg_wdata,
  output logic [XLEN-1:0] cfg_rdata
);

  localparam logic [XLEN-1:0] EPC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q;
  logic            trap_req_q;
  logic [XLEN-1:0] trap_vec_q;
  logic [3:0]      trap_code_q;

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic            mtie_q, mtie_d, meie_q, meie_d;
  logic            mtip_q, mtip_d, meip_q;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;

  logic       pend_any;
  logic [3:0] pend_code;
  logic       capture, ack, mret;

  intr_prio u_prio (
    .pend_i ({meip_q & meie_q, mtip_q & mtie_q}),
    .any_o  (pend_any),
    .code_o (pend_code)
  );

  assign capture = (state_q == IDLE) && mie_q && pend_any && instr_vld_i;
  assign ack     = (state_q == REQ) && trap_ack_i;
  assign mret    = (state_q == HANDLER) && mret_i;

  // cfg writes first, hardware events override, a fresh timer pulse beats any clear
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtie_d   = mtie_q;
    meie_d   = meie_q;
    mtip_d   = mtip_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (cfg_we) begin
      case (cfg_addr)
        ADDR_MSTATUS: begin
          mie_d  = cfg_wdata[MSTATUS_MIE];
          mpie_d = cfg_wdata[MSTATUS_MPIE];
        end
        ADDR_MIE: begin
          mtie_d = cfg_wdata[IRQ_MT];
          meie_d = cfg_wdata[IRQ_ME];
        end
        ADDR_MTVEC:  mtvec_d  = cfg_wdata;
        ADDR_MEPC:   mepc_d   = cfg_wdata & EPC_MASK;
        ADDR_MCAUSE: mcause_d = cfg_wdata;
        ADDR_MIP:    if (cfg_wdata[IRQ_MT]) mtip_d = 1'b0;
        default: ;
      endcase
    end
    if (capture) begin
      mepc_d   = pc_i & EPC_MASK;
      mcause_d = {1'b1, {(XLEN-5){1'b0}}, pend_code};
    end
    if (ack) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
      if (trap_code_q == CODE_MTI) mtip_d = 1'b0;
    end
    if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
    if (tmr_irq_i) mtip_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtip_q   <= 1'b0;
      meip_q   <= 1'b0;
      mtvec_q  <= MTVEC_RST;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtie_q   <= mtie_d;
      meie_q   <= meie_d;
      mtip_q   <= mtip_d;
      meip_q   <= ext_irq_i;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Vector and code are latched at capture so later CSR writes cannot move them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      trap_req_q  <= 1'b0;
      trap_vec_q  <= '0;
      trap_code_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (capture) begin
          state_q     <= REQ;
          trap_req_q  <= 1'b1;
          trap_vec_q  <= calc_vec(mtvec_q, pend_code);
          trap_code_q <= pend_code;
        end
        REQ: if (trap_ack_i) begin
          state_q    <= HANDLER;
          trap_req_q <= 1'b0;
        end
        HANDLER: if (mret_i) state_q <= IDLE;
        default: begin
          state_q    <= IDLE;
          trap_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MSTATUS: begin
        cfg_rdata[MSTATUS_MIE]  = mie_q;
        cfg_rdata[MSTATUS_MPIE] = mpie_q;
      end
      ADDR_MIE: begin
        cfg_rdata[IRQ_MT] = mtie_q;
        cfg_rdata[IRQ_ME] = meie_q;
      end
      ADDR_MTVEC:  cfg_rdata = mtvec_q;
      ADDR_MEPC:   cfg_rdata = mepc_q;
      ADDR_MCAUSE: cfg_rdata = mcause_q;
      ADDR_MIP: begin
        cfg_rdata[IRQ_MT] = mtip_q;
        cfg_rdata[IRQ_ME] = meip_q;
      end
      default: ;
    endcase
  end

  assign trap_req_o = trap_req_q;
  assign trap_vec_o = trap_vec_q;
  assign epc_o      = mepc_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tmr_irq_i, ext_irq_i, instr_vld_i, trap_ack_i, mret_i;
  logic [31:0] pc_i;
  logic        trap_req_o;
  logic [31:0] trap_vec_o, epc_o;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;

  int checks = 0;
  int errors = 0;

  intr_ctrl dut (
    .clk(clk), .reset(reset), .tmr_irq_i(tmr_irq_i), .ext_irq_i(ext_irq_i),
    .pc_i(pc_i), .instr_vld_i(instr_vld_i), .trap_req_o(trap_req_o),
    .trap_ack_i(trap_ack_i), .trap_vec_o(trap_vec_o), .mret_i(mret_i),
    .epc_o(epc_o), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic pulse_tmr();
    tmr_irq_i = 1'b1;
    tick();
    tmr_irq_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v, exp;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL reset_req got %b exp 0", trap_req_o); errors++; end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      exp = (a == 2) ? 32'h100 : 32'h0;
      checks++; if (v !== exp) begin $display("FAIL reset_csr%0d got %h exp %h", a, v, exp); errors++; end
    end
  endtask

  task automatic test_cfg();
    logic [31:0] v;
    cfg_write(3'd3, 32'h0000_0123);
    rd(3'd3, v); checks++; if (v !== 32'h120) begin $display("FAIL cfg_mepc got %h exp 00000120", v); errors++; end
    cfg_write(3'd4, 32'hDEAD_BEEF);
    rd(3'd4, v); checks++; if (v !== 32'hDEAD_BEEF) begin $display("FAIL cfg_mcause got %h exp deadbeef", v); errors++; end
    cfg_write(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, v); checks++; if (v !== 32'h88) begin $display("FAIL cfg_mstatus got %h exp 00000088", v); errors++; end
    cfg_write(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, v); checks++; if (v !== 32'h880) begin $display("FAIL cfg_mie got %h exp 00000880", v); errors++; end
    cfg_write(3'd0, 32'h0);
    cfg_write(3'd1, 32'h0);
  endtask

  task automatic test_timer();
    logic [31:0] v;
    cfg_write(3'd1, 32'h80);
    cfg_write(3'd0, 32'h8);
    pc_i = 32'h40; instr_vld_i = 1'b1;
    pulse_tmr();
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL tmr_lat1 got %b exp 0", trap_req_o); errors++; end
    tick();
    checks++; if (trap_req_o !== 1'b1) begin $display("FAIL tmr_lat2 got %b exp 1", trap_req_o); errors++; end
    checks++; if (trap_vec_o !== 32'h100) begin $display("FAIL tmr_vec got %h exp 00000100", trap_vec_o); errors++; end
    rd(3'd4, v); checks++; if (v !== 32'h8000_0007) begin $display("FAIL tmr_mcause got %h exp 80000007", v); errors++; end
    checks++; if (epc_o !== 32'h40) begin $display("FAIL tmr_epc got %h exp 00000040", epc_o); errors++; end
    cfg_write(3'd1, 32'h0);
    tick(); tick();
    checks++; if (trap_req_o !== 1'b1) begin $display("FAIL tmr_hold got %b exp 1", trap_req_o); errors++; end
    // ack coincides with a cfg write of mstatus; the hardware update must win
    trap_ack_i = 1'b1;
    cfg_write(3'd0, 32'h8);
    trap_ack_i = 1'b0;
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL tmr_ackreq got %b exp 0", trap_req_o); errors++; end
    rd(3'd0, v); checks++; if (v !== 32'h80) begin $display("FAIL tmr_ack_mstatus got %h exp 00000080", v); errors++; end
    rd(3'd5, v); checks++; if (v !== 32'h0) begin $display("FAIL tmr_ack_mip got %h exp 00000000", v); errors++; end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    rd(3'd0, v); checks++; if (v !== 32'h88) begin $display("FAIL tmr_mret_mstatus got %h exp 00000088", v); errors++; end
  endtask

  task automatic test_vectored();
    logic [31:0] v;
    cfg_write(3'd2, 32'h101);
    cfg_write(3'd1, 32'h880);
    ext_irq_i = 1'b1;
    pulse_tmr();
    tick();
    checks++; if (trap_req_o !== 1'b1) begin $display("FAIL vec_req got %b exp 1", trap_req_o); errors++; end
    checks++; if (trap_vec_o !== 32'h12C) begin $display("FAIL vec_mei got %h exp 0000012c", trap_vec_o); errors++; end
    rd(3'd4, v); checks++; if (v !== 32'h8000_000B) begin $display("FAIL vec_mcause got %h exp 8000000b", v); errors++; end
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    rd(3'd5, v); checks++; if (v !== 32'h880) begin $display("FAIL vec_mip got %h exp 00000880", v); errors++; end
    rd(3'd0, v); checks++; if (v !== 32'h80) begin $display("FAIL vec_mstatus got %h exp 00000080", v); errors++; end
  endtask

  task automatic test_mret();
    logic [31:0] v;
    ext_irq_i = 1'b0;
    tick(); tick();
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL mret_handler_req got %b exp 0", trap_req_o); errors++; end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    rd(3'd0, v); checks++; if (v !== 32'h88) begin $display("FAIL mret_mstatus got %h exp 00000088", v); errors++; end
    tick();
    checks++; if (trap_req_o !== 1'b1) begin $display("FAIL mret_rereq got %b exp 1", trap_req_o); errors++; end
    checks++; if (trap_vec_o !== 32'h11C) begin $display("FAIL mret_vec got %h exp 0000011c", trap_vec_o); errors++; end
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    cfg_write(3'd0, 32'h0);
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    rd(3'd0, v); checks++; if (v !== 32'h0) begin $display("FAIL mret_idle_ignored got %h exp 00000000", v); errors++; end
  endtask

  task automatic test_masked();
    logic [31:0] v;
    pulse_tmr();
    tick();
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL mask_req got %b exp 0", trap_req_o); errors++; end
    rd(3'd5, v); checks++; if (v !== 32'h80) begin $display("FAIL mask_mip got %h exp 00000080", v); errors++; end
    tmr_irq_i = 1'b1;
    cfg_write(3'd5, 32'h80);
    tmr_irq_i = 1'b0;
    rd(3'd5, v); checks++; if (v !== 32'h80) begin $display("FAIL mask_clr_vs_pulse got %h exp 00000080", v); errors++; end
    cfg_write(3'd5, 32'h80);
    rd(3'd5, v); checks++; if (v !== 32'h0) begin $display("FAIL mask_clr got %h exp 00000000", v); errors++; end
  endtask

  task automatic test_instr_vld();
    instr_vld_i = 1'b0; pc_i = 32'h88;
    cfg_write(3'd0, 32'h8);
    pulse_tmr();
    tick(); tick();
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL vld_noreq got %b exp 0", trap_req_o); errors++; end
    checks++; if (epc_o !== 32'h40) begin $display("FAIL vld_nocapture got %h exp 00000040", epc_o); errors++; end
    instr_vld_i = 1'b1;
    tick();
    checks++; if (trap_req_o !== 1'b1) begin $display("FAIL vld_req got %b exp 1", trap_req_o); errors++; end
    checks++; if (epc_o !== 32'h88) begin $display("FAIL vld_epc got %h exp 00000088", epc_o); errors++; end
    checks++; if (trap_vec_o !== 32'h11C) begin $display("FAIL vld_vec got %h exp 0000011c", trap_vec_o); errors++; end
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] v, exp;
    reset = 1'b1;
    tick();
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL rst_mid_req got %b exp 0", trap_req_o); errors++; end
    checks++; if (epc_o !== 32'h0) begin $display("FAIL rst_mid_epc got %h exp 00000000", epc_o); errors++; end
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v);
      exp = (a == 2) ? 32'h100 : 32'h0;
      checks++; if (v !== exp) begin $display("FAIL rst_mid_csr%0d got %h exp %h", a, v, exp); errors++; end
    end
    reset = 1'b0;
    tick();
    checks++; if (trap_req_o !== 1'b0) begin $display("FAIL rst_after_req got %b exp 0", trap_req_o); errors++; end
  endtask

  initial begin
    reset = 1'b1; tmr_irq_i = 1'b0; ext_irq_i = 1'b0; instr_vld_i = 1'b0;
    trap_ack_i = 1'b0; mret_i = 1'b0; pc_i = 32'h0;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'h0;
    test_reset();
    test_cfg();
    test_timer();
    test_vectored();
    test_mret();
    test_masked();
    test_instr_vld();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
